calculator_dec_seq: RTL and testbench

- Clocked, parametrised successor to the combinational decimal-keypad calculator front end.
- Accepts multi-digit decimal operands from one-hot key strobes, an operator, and an equals strobe.
- Computes +, -, *, / (sequential restoring divider), AND and OR, and returns a registered result with a valid pulse.
- Sits between the keypad debouncer/strobe generator and the display driver.

---
 rtl/calculator_dec_seq.sv | 274 +++++++++++++++++++++++++++
 tb/tb_calculator_dec_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculator_dec_seq.sv
// calculator_dec_seq: clocked decimal-keypad calculator front end.
// Builds multi-digit decimal operands from one-hot key strobes, then applies
// +, -, *, / (sequential restoring divider), AND or OR on the equals strobe.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   digit/_valid    : one-hot decimal key and its single-cycle strobe
//   func/_valid     : operator code and its single-cycle strobe
//   get_res, clear  : equals strobe, synchronous clear of all state
//   operand         : operand being entered (B while entering B, else A)
//   res/neg         : registered result magnitude and subtraction sign
//   res_valid       : one-cycle pulse when res is updated
//   busy            : divider running, key strobes ignored
//   error           : sticky error flag
module calculator_dec_seq #(
   parameter int DIGITS    = 2,
   parameter int WIDTH     = 8,
   parameter int RES_WIDTH = 2*WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [9:0]           digit,
   input  logic                 digit_valid,
   input  logic [2:0]           func,
   input  logic                 func_valid,
   input  logic                 get_res,
   input  logic                 clear,
   output logic [WIDTH-1:0]     operand,
   output logic [RES_WIDTH-1:0] res,
   output logic                 neg,
   output logic                 res_valid,
   output logic                 busy,
   output logic                 error
);

   localparam int CW  = $clog2(DIGITS+1);
   localparam int DCW = $clog2(WIDTH+1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;

   typedef enum logic [2:0] {
      S_ENTER_A,
      S_ENTER_B,
      S_DIVIDE,
      S_RESULT,
      S_ERROR
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [WIDTH-1:0]      r_a, w_a_nxt;
   logic [WIDTH-1:0]      r_b, w_b_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic [2:0]            r_op, w_op_nxt;
   logic [RES_WIDTH-1:0]  r_res, w_res_nxt;
   logic                  r_neg, w_neg_nxt;
   logic                  r_res_valid, w_res_valid_nxt;
   logic                  r_error, w_error_nxt;
   logic [WIDTH-1:0]      r_quo, w_quo_nxt;
   logic [WIDTH-1:0]      r_rem, w_rem_nxt;
   logic [DCW-1:0]        r_dcnt, w_dcnt_nxt;

   logic [3:0]            w_key;
   logic                  w_onehot;
   logic                  w_digit_ok;
   logic                  w_func_bad;
   logic [WIDTH-1:0]      w_a_app;
   logic [WIDTH-1:0]      w_b_app;
   logic [WIDTH:0]        w_shift;
   logic                  w_ge;
   logic [WIDTH-1:0]      w_sub;
   logic [WIDTH-1:0]      w_step_quo;
   logic [WIDTH-1:0]      w_step_rem;

   // Key decode: index of the set bit; only trusted when w_onehot is true.
   always_comb begin
      w_key = 4'd0;
      for (int k = 0; k < 10; k++) begin
         if (digit[k]) w_key = 4'(k);
      end
   end

   assign w_onehot   = (digit != 10'd0) && ((digit & (digit - 10'd1)) == 10'd0);
   assign w_digit_ok = digit_valid && w_onehot && (r_cnt < CW'(DIGITS));
   assign w_func_bad = (func[2:1] == 2'b11);
   assign w_a_app    = r_a * WIDTH'(10) + WIDTH'(w_key);
   assign w_b_app    = r_b * WIDTH'(10) + WIDTH'(w_key);

   // One restoring-division step: shift the next dividend bit into the
   // remainder, subtract the divisor when it fits. The remainder is always
   // below the divisor, so the subtraction fits in WIDTH bits.
   assign w_shift    = {r_rem, r_quo[WIDTH-1]};
   assign w_ge       = (w_shift >= {1'b0, r_b});
   assign w_sub      = w_shift[WIDTH-1:0] - r_b;
   assign w_step_rem = w_ge ? w_sub : w_shift[WIDTH-1:0];
   assign w_step_quo = {r_quo[WIDTH-2:0], w_ge};

   always_comb begin
      w_state_nxt     = r_state;
      w_a_nxt         = r_a;
      w_b_nxt         = r_b;
      w_cnt_nxt       = r_cnt;
      w_op_nxt        = r_op;
      w_res_nxt       = r_res;
      w_neg_nxt       = r_neg;
      w_res_valid_nxt = 1'b0;
      w_error_nxt     = r_error;
      w_quo_nxt       = r_quo;
      w_rem_nxt       = r_rem;
      w_dcnt_nxt      = r_dcnt;

      if (clear) begin
         w_state_nxt = S_ENTER_A;
         w_a_nxt     = '0;
         w_b_nxt     = '0;
         w_cnt_nxt   = '0;
         w_op_nxt    = '0;
         w_res_nxt   = '0;
         w_neg_nxt   = 1'b0;
         w_error_nxt = 1'b0;
         w_quo_nxt   = '0;
         w_rem_nxt   = '0;
         w_dcnt_nxt  = '0;
      end else begin
         // Each branch below tests strobes in priority order, so a
         // higher-priority strobe always swallows the lower ones.
         case (r_state)
            S_ENTER_A: begin
               if (get_res) begin
                  w_res_nxt       = RES_WIDTH'(r_a);
                  w_neg_nxt       = 1'b0;
                  w_res_valid_nxt = 1'b1;
                  w_state_nxt     = S_RESULT;
               end else if (func_valid) begin
                  if (w_func_bad) begin
                     w_error_nxt = 1'b1;
                     w_state_nxt = S_ERROR;
                  end else begin
                     w_op_nxt    = func;
                     w_b_nxt     = '0;
                     w_cnt_nxt   = '0;
                     w_state_nxt = S_ENTER_B;
                  end
               end else if (w_digit_ok) begin
                  w_a_nxt   = w_a_app;
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end

            S_ENTER_B: begin
               if (get_res) begin
                  w_neg_nxt       = 1'b0;
                  w_res_valid_nxt = 1'b1;
                  w_state_nxt     = S_RESULT;
                  case (r_op)
                     OP_ADD: w_res_nxt = RES_WIDTH'(r_a) + RES_WIDTH'(r_b);
                     OP_SUB: begin
                        w_res_nxt = (r_a >= r_b) ? RES_WIDTH'(r_a - r_b)
                                                 : RES_WIDTH'(r_b - r_a);
                        w_neg_nxt = (r_a < r_b);
                     end
                     OP_MUL: w_res_nxt = RES_WIDTH'(r_a) * RES_WIDTH'(r_b);
                     OP_AND: w_res_nxt = RES_WIDTH'(r_a & r_b);
                     OP_OR:  w_res_nxt = RES_WIDTH'(r_a | r_b);
                     default: begin
                        // Division: result appears only when the divider ends.
                        w_res_valid_nxt = 1'b0;
                        w_neg_nxt       = r_neg;
                        if (r_b == '0) begin
                           w_error_nxt = 1'b1;
                           w_state_nxt = S_ERROR;
                        end else begin
                           w_quo_nxt   = r_a;
                           w_rem_nxt   = '0;
                           w_dcnt_nxt  = '0;
                           w_state_nxt = S_DIVIDE;
                        end
                     end
                  endcase
               end else if (func_valid) begin
                  if (w_func_bad) begin
                     w_error_nxt = 1'b1;
                     w_state_nxt = S_ERROR;
                  end else if (r_cnt == '0) begin
                     w_op_nxt = func;
                  end
               end else if (w_digit_ok) begin
                  w_b_nxt   = w_b_app;
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end

            S_DIVIDE: begin
               w_quo_nxt  = w_step_quo;
               w_rem_nxt  = w_step_rem;
               w_dcnt_nxt = r_dcnt + DCW'(1);
               if (r_dcnt == DCW'(WIDTH-1)) begin
                  w_res_nxt       = RES_WIDTH'(w_step_quo);
                  w_neg_nxt       = 1'b0;
                  w_res_valid_nxt = 1'b1;
                  w_state_nxt     = S_RESULT;
               end
            end

            S_RESULT: begin
               if (get_res) begin
                  w_state_nxt = S_RESULT;
               end else if (func_valid) begin
                  // Chaining reuses res as A only if it fits an operand.
                  if (w_func_bad || r_neg || (r_res[RES_WIDTH-1:WIDTH] != '0)) begin
                     w_error_nxt = 1'b1;
                     w_state_nxt = S_ERROR;
                  end else begin
                     w_a_nxt     = r_res[WIDTH-1:0];
                     w_op_nxt    = func;
                     w_b_nxt     = '0;
                     w_cnt_nxt   = '0;
                     w_state_nxt = S_ENTER_B;
                  end
               end else if (digit_valid && w_onehot) begin
                  w_a_nxt     = WIDTH'(w_key);
                  w_cnt_nxt   = CW'(1);
                  w_state_nxt = S_ENTER_A;
               end
            end

            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_ENTER_A;
         r_a         <= '0;
         r_b         <= '0;
         r_cnt       <= '0;
         r_op        <= '0;
         r_res       <= '0;
         r_neg       <= 1'b0;
         r_res_valid <= 1'b0;
         r_error     <= 1'b0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_dcnt      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_cnt       <= w_cnt_nxt;
         r_op        <= w_op_nxt;
         r_res       <= w_res_nxt;
         r_neg       <= w_neg_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_error     <= w_error_nxt;
         r_quo       <= w_quo_nxt;
         r_rem       <= w_rem_nxt;
         r_dcnt      <= w_dcnt_nxt;
      end
   end

   assign operand   = (r_state == S_ENTER_B) ? r_b : r_a;
   assign res       = r_res;
   assign neg       = r_neg;
   assign res_valid = r_res_valid;
   assign busy      = (r_state == S_DIVIDE);
   assign error     = r_error;

endmodule

// File: tb/tb_calculator_dec_seq.sv
module tb_calculator_dec_seq;

   localparam int DIGITS = 2;
   localparam int WIDTH  = 8;
   localparam int RW     = 2*WIDTH;

   localparam int M_A = 0;
   localparam int M_B = 1;
   localparam int M_R = 2;
   localparam int M_E = 3;

   logic          clk;
   logic          reset;
   logic [9:0]    digit;
   logic          digit_valid;
   logic [2:0]    func;
   logic          func_valid;
   logic          get_res;
   logic          clear;
   logic [WIDTH-1:0] operand;
   logic [RW-1:0] res;
   logic          neg;
   logic          res_valid;
   logic          busy;
   logic          error;

   int checks = 0;
   int errors = 0;

   // Keystroke-level reference model
   int m_mode, m_a, m_b, m_cnt, m_op, m_res, m_neg, m_err;

   calculator_dec_seq #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .digit(digit), .digit_valid(digit_valid),
      .func(func), .func_valid(func_valid), .get_res(get_res), .clear(clear),
      .operand(operand), .res(res), .neg(neg), .res_valid(res_valid),
      .busy(busy), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_mode = M_A; m_a = 0; m_b = 0; m_cnt = 0; m_op = 0;
      m_res = 0; m_neg = 0; m_err = 0;
   endtask

   task automatic model_digit(input int k);
      if (m_mode == M_A && m_cnt < DIGITS) begin
         m_a = m_a*10 + k; m_cnt++;
      end else if (m_mode == M_B && m_cnt < DIGITS) begin
         m_b = m_b*10 + k; m_cnt++;
      end else if (m_mode == M_R) begin
         m_mode = M_A; m_a = k; m_cnt = 1;
      end
   endtask

   task automatic model_op(input int f);
      if (m_mode == M_A || m_mode == M_B || m_mode == M_R) begin
         if (f >= 6) begin
            m_err = 1; m_mode = M_E;
         end else if (m_mode == M_A) begin
            m_op = f; m_b = 0; m_cnt = 0; m_mode = M_B;
         end else if (m_mode == M_B) begin
            if (m_cnt == 0) m_op = f;
         end else if (m_neg != 0 || m_res >= (1 << WIDTH)) begin
            m_err = 1; m_mode = M_E;
         end else begin
            m_a = m_res; m_op = f; m_b = 0; m_cnt = 0; m_mode = M_B;
         end
      end
   endtask

   // kind: 0 ignored, 1 result next cycle, 2 divide, 3 error
   task automatic model_eq(output int kind);
      kind = 0;
      if (m_mode == M_A) begin
         m_res = m_a; m_neg = 0; m_mode = M_R; kind = 1;
      end else if (m_mode == M_B) begin
         kind = 1; m_neg = 0; m_mode = M_R;
         case (m_op)
            0: m_res = m_a + m_b;
            1: begin
               m_res = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
               m_neg = (m_a < m_b) ? 1 : 0;
            end
            2: m_res = m_a * m_b;
            4: m_res = m_a & m_b;
            5: m_res = m_a | m_b;
            default: begin
               if (m_b == 0) begin
                  kind = 3; m_err = 1; m_mode = M_E;
               end else begin
                  kind = 2; m_res = m_a / m_b;
               end
            end
         endcase
      end
   endtask

   task automatic press(input logic [9:0] d, input logic dv, input logic [2:0] f,
                        input logic fv, input logic gr, input logic clr);
      digit = d; digit_valid = dv; func = f; func_valid = fv;
      get_res = gr; clear = clr;
      @(negedge clk);
      digit = '0; digit_valid = 1'b0; func = '0; func_valid = 1'b0;
      get_res = 1'b0; clear = 1'b0;
   endtask

   task automatic chk_entry();
      chk("error", 32'(error), 32'(m_err));
      if (m_mode == M_A) chk("operand_a", 32'(operand), 32'(m_a));
      if (m_mode == M_B) chk("operand_b", 32'(operand), 32'(m_b));
   endtask

   task automatic t_digit(input int k);
      logic [9:0] d;
      d = 10'd1 << k;
      press(d, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      model_digit(k);
      chk_entry();
   endtask

   task automatic t_op(input int f);
      press(10'd0, 1'b0, 3'(f), 1'b1, 1'b0, 1'b0);
      model_op(f);
      chk_entry();
   endtask

   task automatic t_clear();
      press(10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      model_clear();
      chk("clr_error", 32'(error), 32'd0);
      chk("clr_operand", 32'(operand), 32'd0);
      chk("clr_res", 32'(res), 32'd0);
   endtask

   task automatic t_eq(input int inj_at, input int rst_at);
      int   kind;
      bit   aborted;
      logic exp_v, exp_b;
      model_eq(kind);
      press(10'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      aborted = 1'b0;
      for (int t = 0; t <= WIDTH+1; t++) begin
         exp_v = !aborted && ((kind == 1 && t == 0) || (kind == 2 && t == WIDTH));
         exp_b = !aborted && kind == 2 && t < WIDTH;
         chk("res_valid", 32'(res_valid), 32'(exp_v));
         chk("busy", 32'(busy), 32'(exp_b));
         if (t == rst_at) begin
            reset = 1'b1; aborted = 1'b1; model_clear();
         end
         if (t == inj_at) begin
            digit = 10'd1 << 5; digit_valid = 1'b1;
         end
         @(negedge clk);
         reset = 1'b0; digit = '0; digit_valid = 1'b0;
      end
      chk("res", 32'(res), 32'(m_res));
      chk("neg", 32'(neg), 32'(m_neg));
      chk("eq_error", 32'(error), 32'(m_err));
   endtask

   initial begin
      int nd;
      reset = 1'b1; digit = '0; digit_valid = 1'b0; func = '0;
      func_valid = 1'b0; get_res = 1'b0; clear = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_neg", 32'(neg), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_operand", 32'(operand), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 12 + 34
      t_digit(1); t_digit(2); t_op(0); t_digit(3); t_digit(4); t_eq(-1, -1);
      chk("sum46", 32'(res), 32'd46);

      // 7 - 9, then chaining a negative result is an error
      t_digit(7); t_op(1); t_digit(9); t_eq(-1, -1);
      chk("sub_neg", 32'(neg), 32'd1);
      t_op(0);
      chk("chain_neg_err", 32'(error), 32'd1);
      t_clear();

      // 99 * 99, then digit cap with a non-one-hot key in between
      t_digit(9); t_digit(9); t_op(2); t_digit(9); t_digit(9); t_eq(-1, -1);
      chk("mul9801", 32'(res), 32'd9801);
      t_digit(1);
      press(10'b0000000011, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      chk_entry();
      t_digit(2); t_digit(3);
      chk("cap12", 32'(operand), 32'd12);
      t_clear();

      // 99 / 7 with a digit strobe while busy; then divide by zero
      t_digit(9); t_digit(9); t_op(3); t_digit(7); t_eq(2, -1);
      chk("div14", 32'(res), 32'd14);
      t_digit(5); t_op(3); t_digit(0); t_eq(-1, -1);
      chk("div0_err", 32'(error), 32'd1);
      t_clear();

      // Chaining 2+3=5, *4=20
      t_digit(2); t_op(0); t_digit(3); t_eq(-1, -1);
      t_op(2); t_digit(4); t_eq(-1, -1);
      chk("chain20", 32'(res), 32'd20);
      t_clear();

      // Same-cycle digit and operator: operator wins, digit dropped
      press(10'd1 << 5, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
      model_op(0);
      chk_entry();
      t_digit(3); t_eq(-1, -1);
      chk("combo3", 32'(res), 32'd3);
      t_clear();

      // Reset during the 4th divide cycle
      t_digit(9); t_digit(9); t_op(3); t_digit(7); t_eq(-1, 3);
      chk("abort_res", 32'(res), 32'd0);

      // 6 AND 3, then illegal opcode
      t_digit(6); t_op(4); t_digit(3); t_eq(-1, -1);
      chk("and2", 32'(res), 32'd2);
      t_op(6);
      chk("illegal_err", 32'(error), 32'd1);
      t_clear();

      // Randomized keystroke sequences against the model
      for (int s = 0; s < 24; s++) begin
         if (m_mode == M_R && $urandom_range(1, 0) == 1) begin
            t_op(int'($urandom_range(5, 0)));
         end else begin
            nd = int'($urandom_range(3, 0));
            for (int i = 0; i < nd; i++) t_digit(int'($urandom_range(9, 0)));
            t_op(int'($urandom_range(5, 0)));
            if ($urandom_range(3, 0) == 0) t_op(int'($urandom_range(5, 0)));
         end
         nd = int'($urandom_range(3, 0));
         for (int i = 0; i < nd; i++) t_digit(int'($urandom_range(9, 0)));
         t_eq(-1, -1);
         if ($urandom_range(3, 0) == 0) t_eq(-1, -1);
         if (m_mode == M_E) t_clear();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
